cache_line_responder: RTL



---
 rtl/cache_line_responder_pkg.sv | 28 ++
 rtl/cache_line_responder_if.sv | 22 ++
 rtl/cache_line_responder_line_store.sv | 31 +++
 rtl/cache_line_responder.sv | 111 +++++++++++
 4 files changed

// File: rtl/cache_line_responder_pkg.sv
// Shared types and constants for the line-granular memory responder.
package cache_responder_types;

   localparam int LINE_W      = 256;
   localparam int OFFSET_BITS = 5;
   localparam int ADDR_W      = 32;
   localparam int IDX_MAX_W   = ADDR_W - OFFSET_BITS;
   localparam int CNT_W       = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2,
      TURN = 2'd3
   } state_e;

   typedef struct packed {
      logic [IDX_MAX_W-1:0] idx;
      logic                 is_write;
      logic [LINE_W-1:0]    wdata;
   } req_t;

   // Full line number of a byte address; callers keep only the low bits they store.
   function automatic logic [IDX_MAX_W-1:0] line_index(input logic [ADDR_W-1:0] addr);
      return IDX_MAX_W'(addr >> OFFSET_BITS);
   endfunction

endpackage

// File: rtl/cache_line_responder_if.sv
// Downward-facing cache port: one line request in, one completion pulse out.
interface cache_line_responder_if;
   import cache_responder_types::*;

   logic [ADDR_W-1:0] dfp_addr;
   logic              dfp_read;
   logic              dfp_write;
   logic [LINE_W-1:0] dfp_wdata;
   logic [LINE_W-1:0] dfp_rdata;
   logic              dfp_resp;

   modport master (
      output dfp_addr, dfp_read, dfp_write, dfp_wdata,
      input  dfp_rdata, dfp_resp
   );

   modport slave (
      input  dfp_addr, dfp_read, dfp_write, dfp_wdata,
      output dfp_rdata, dfp_resp
   );

endinterface

// File: rtl/cache_line_responder_line_store.sv
// Single-port line array: synchronous clear, combinational read, gated write.
module line_store
   import cache_responder_types::*;
#(
   parameter int DEPTH_LOG2 = 6
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  i_we,
   input  logic [DEPTH_LOG2-1:0] i_addr,
   input  logic [LINE_W-1:0]     i_wdata,
   output logic [LINE_W-1:0]     o_rdata
);

   localparam int DEPTH = 1 << DEPTH_LOG2;

   logic [LINE_W-1:0] r_mem [DEPTH];

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
      end else if (i_we) begin
         r_mem[i_addr] <= i_wdata;
      end
   end

   assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/cache_line_responder.sv
// Fixed-latency line responder: FSM, latency down-counter, request capture and stats.
//
//   state | meaning
//   IDLE  | waiting for exactly one of read/write; both high flags err
//   WAIT  | counting down the remaining latency, inputs ignored
//   RESP  | one-cycle dfp_resp; write commits and counter bumps on exit edge
//   TURN  | bubble so a registered initiator can drop its request
module cache_line_responder
   import cache_responder_types::*;
#(
   parameter int LATENCY    = 4,
   parameter int DEPTH_LOG2 = 6
) (
   input  logic                   clk,
   input  logic                   rst,
   cache_line_responder_if.slave  dfp,
   output logic                   err,
   output logic [31:0]            rd_count,
   output logic [31:0]            wr_count
);

   localparam logic [CNT_W-1:0] LAT_M1 = CNT_W'(LATENCY - 1);

   state_e                r_state;
   state_e                w_state_nxt;
   logic [CNT_W-1:0]      r_cnt;
   logic [CNT_W-1:0]      w_cnt_nxt;
   req_t                  r_req;
   req_t                  w_req_nxt;
   logic                  r_err;
   logic                  w_illegal;
   logic [31:0]           r_rd_count;
   logic [31:0]           r_wr_count;
   logic                  w_we;
   logic [DEPTH_LOG2-1:0] w_idx;
   logic [LINE_W-1:0]     w_line;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= IDLE;
         r_cnt      <= '0;
         r_req      <= '0;
         r_err      <= 1'b0;
         r_rd_count <= '0;
         r_wr_count <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_req   <= w_req_nxt;
         r_err   <= w_illegal;
         if (r_state == RESP) begin
            if (r_req.is_write) begin
               r_wr_count <= r_wr_count + 32'd1;
            end else begin
               r_rd_count <= r_rd_count + 32'd1;
            end
         end
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_req_nxt   = r_req;
      w_illegal   = 1'b0;
      case (r_state)
         IDLE: begin
            if (dfp.dfp_read && dfp.dfp_write) begin
               w_illegal = 1'b1;
            end else if (dfp.dfp_read || dfp.dfp_write) begin
               w_req_nxt.idx      = line_index(dfp.dfp_addr);
               w_req_nxt.is_write = dfp.dfp_write;
               w_req_nxt.wdata    = dfp.dfp_wdata;
               w_cnt_nxt          = LAT_M1;
               w_state_nxt        = (LATENCY == 1) ? RESP : WAIT;
            end
         end
         WAIT: begin
            // Leaving on the count of 1 lands RESP exactly LATENCY cycles after acceptance.
            w_cnt_nxt = r_cnt - CNT_W'(1);
            if (r_cnt <= CNT_W'(1)) begin
               w_state_nxt = RESP;
            end
         end
         RESP:    w_state_nxt = TURN;
         TURN:    w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   assign w_idx = DEPTH_LOG2'(r_req.idx);
   assign w_we  = (r_state == RESP) && r_req.is_write;

   line_store #(
      .DEPTH_LOG2 (DEPTH_LOG2)
   ) u_line_store (
      .clk     (clk),
      .rst     (rst),
      .i_we    (w_we),
      .i_addr  (w_idx),
      .i_wdata (r_req.wdata),
      .o_rdata (w_line)
   );

   assign dfp.dfp_resp  = (r_state == RESP);
   assign dfp.dfp_rdata = ((r_state == RESP) && !r_req.is_write) ? w_line : '0;
   assign err           = r_err;
   assign rd_count      = r_rd_count;
   assign wr_count      = r_wr_count;

endmodule
